// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline control bundle: hazard/redirect/occupancy requests in, stage controls out.
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             stall_id_req;
  logic             branch_taken_ex;
  logic             muldiv_ex;
  logic             mem_busy;
  logic             en_pc;
  logic             en_if_id;
  logic             en_id_ex;
  logic             en_ex_mem;
  logic             en_mem_wb;
  logic             flush_if_id;
  logic             bubble_id_ex;
  logic             bubble_ex_mem;
  logic             muldiv_busy;
  logic             muldiv_done;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline side: raises requests, consumes stage controls.
  modport master (
    output stall_id_req, branch_taken_ex, muldiv_ex, mem_busy,
    input  en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
    input  flush_if_id, bubble_id_ex, bubble_ex_mem,
    input  muldiv_busy, muldiv_done, stall_cycles
  );

  // Sequencer side.
  modport slave (
    input  stall_id_req, branch_taken_ex, muldiv_ex, mem_busy,
    output en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
    output flush_if_id, bubble_id_ex, bubble_ex_mem,
    output muldiv_busy, muldiv_done, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central 5-stage pipeline sequencer: stage enables, flush/bubble, mul/div occupancy, stall counter.
module pipe_stall_ctrl #(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input logic              clk,
  input logic              reset,
  pipe_stall_ctrl_if.slave bus
);

  localparam int unsigned MD_CNT_W = 4;
  // Entry cycle and done cycle are both EX cycles, so the counter covers the rest.
  localparam logic [MD_CNT_W-1:0] MD_INIT = MD_CNT_W'(MULDIV_LAT - 2);

  typedef enum logic {RUN, MD_BUSY} state_e;

  state_e              state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;

  logic en_pc_c, en_if_id_c, en_id_ex_c, en_ex_mem_c, en_mem_wb_c;
  logic flush_if_id_c, bubble_id_ex_c, bubble_ex_mem_c, muldiv_done_c;

  // Prioritised control rules plus mul/div FSM next state.
  always_comb begin
    state_d         = state_q;
    md_cnt_d        = md_cnt_q;
    en_pc_c         = 1'b1;
    en_if_id_c      = 1'b1;
    en_id_ex_c      = 1'b1;
    en_ex_mem_c     = 1'b1;
    en_mem_wb_c     = 1'b1;
    flush_if_id_c   = 1'b0;
    bubble_id_ex_c  = 1'b0;
    bubble_ex_mem_c = 1'b0;
    muldiv_done_c   = 1'b0;

    if (bus.mem_busy) begin
      // Memory wait freezes the whole pipe, including the mul/div countdown.
      en_pc_c     = 1'b0;
      en_if_id_c  = 1'b0;
      en_id_ex_c  = 1'b0;
      en_ex_mem_c = 1'b0;
      en_mem_wb_c = 1'b0;
    end else if ((state_q == MD_BUSY && md_cnt_q != '0) ||
                 (state_q == RUN && bus.muldiv_ex && !bus.branch_taken_ex)) begin
      // Mul/div occupies EX: hold front end, drain bubbles into MEM.
      en_pc_c         = 1'b0;
      en_if_id_c      = 1'b0;
      en_id_ex_c      = 1'b0;
      bubble_ex_mem_c = 1'b1;
      if (state_q == RUN) begin
        state_d  = MD_BUSY;
        md_cnt_d = MD_INIT;
      end else begin
        md_cnt_d = md_cnt_q - MD_CNT_W'(1);
      end
    end else begin
      // Last mul/div cycle advances everything; flush/bubble still follow redirect/hazard.
      if (state_q == MD_BUSY) begin
        muldiv_done_c = 1'b1;
        state_d       = RUN;
      end
      if (bus.branch_taken_ex) begin
        flush_if_id_c  = 1'b1;
        bubble_id_ex_c = 1'b1;
      end else if (bus.stall_id_req) begin
        bubble_id_ex_c = 1'b1;
        if (state_q == RUN) begin
          en_pc_c    = 1'b0;
          en_if_id_c = 1'b0;
        end
      end
    end

    stall_cycles_d = stall_cycles_q;
    if (!en_pc_c && stall_cycles_q != '1) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // State, mul/div counter and stall counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= RUN;
      md_cnt_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      md_cnt_q       <= md_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // All controls are forced inactive while reset is held.
  assign bus.en_pc         = !reset && en_pc_c;
  assign bus.en_if_id      = !reset && en_if_id_c;
  assign bus.en_id_ex      = !reset && en_id_ex_c;
  assign bus.en_ex_mem     = !reset && en_ex_mem_c;
  assign bus.en_mem_wb     = !reset && en_mem_wb_c;
  assign bus.flush_if_id   = !reset && flush_if_id_c;
  assign bus.bubble_id_ex  = !reset && bubble_id_ex_c;
  assign bus.bubble_ex_mem = !reset && bubble_ex_mem_c;
  assign bus.muldiv_done   = !reset && muldiv_done_c;
  assign bus.muldiv_busy   = !reset && (state_q == MD_BUSY);
  assign bus.stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: two instances (16-bit and 4-bit stall counters) share stimulus.
module tb_pipe_stall_ctrl;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall_id_req = 1'b0;
  logic branch_taken_ex = 1'b0;
  logic muldiv_ex = 1'b0;
  logic mem_busy = 1'b0;

  int tests = 0;
  int fails = 0;

  // Model state: remaining EX cycles of the current mul/div op (0 = none) and expected counters.
  int rem = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  logic [9:0] last_vec;

  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_W(16)) bus_a ();
  pipe_stall_ctrl_if #(.CNT_W(4))  bus_b ();

  assign bus_a.stall_id_req    = stall_id_req;
  assign bus_a.branch_taken_ex = branch_taken_ex;
  assign bus_a.muldiv_ex       = muldiv_ex;
  assign bus_a.mem_busy        = mem_busy;
  assign bus_b.stall_id_req    = stall_id_req;
  assign bus_b.branch_taken_ex = branch_taken_ex;
  assign bus_b.muldiv_ex       = muldiv_ex;
  assign bus_b.mem_busy        = mem_busy;

  pipe_stall_ctrl #(.MULDIV_LAT(LAT), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  pipe_stall_ctrl #(.MULDIV_LAT(LAT), .CNT_W(4))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Vector order: en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush, bubble_id_ex, bubble_ex_mem, busy, done
  function automatic logic [9:0] vec_a();
    return {bus_a.en_pc, bus_a.en_if_id, bus_a.en_id_ex, bus_a.en_ex_mem, bus_a.en_mem_wb,
            bus_a.flush_if_id, bus_a.bubble_id_ex, bus_a.bubble_ex_mem,
            bus_a.muldiv_busy, bus_a.muldiv_done};
  endfunction

  function automatic logic [9:0] vec_b();
    return {bus_b.en_pc, bus_b.en_if_id, bus_b.en_id_ex, bus_b.en_ex_mem, bus_b.en_mem_wb,
            bus_b.flush_if_id, bus_b.bubble_id_ex, bus_b.bubble_ex_mem,
            bus_b.muldiv_busy, bus_b.muldiv_done};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what the pipe must do this cycle given remaining mul/div work.
  task automatic model_step(input logic s, input logic b, input logic m, input logic mb,
                            output logic [9:0] e, output int rem_n);
    logic occ, done, front, busy;
    int   cur;
    busy  = (rem > 0);
    occ   = busy || (m && !b);
    cur   = busy ? rem : LAT;
    rem_n = rem;
    if (mb) begin
      e = {8'b0, busy, 1'b0};
    end else if (occ && cur > 1) begin
      e     = {3'b000, 2'b11, 1'b0, 1'b0, 1'b1, busy, 1'b0};
      rem_n = cur - 1;
    end else begin
      done  = busy;
      rem_n = 0;
      front = !(s && !b && !done);
      e     = {front, front, 3'b111, b, b | s, 1'b0, busy, done};
    end
  endtask

  // One clock cycle: apply inputs, compare at mid-cycle, commit model on the edge.
  task automatic cycle(input logic s, input logic b, input logic m, input logic mb);
    logic [9:0] e;
    int         rn;
    stall_id_req    = s;
    branch_taken_ex = b;
    muldiv_ex       = m;
    mem_busy        = mb;
    #4;
    model_step(s, b, m, mb, e, rn);
    last_vec = vec_a();
    chk("ctl_a", 32'(vec_a()), 32'(e));
    chk("ctl_b", 32'(vec_b()), 32'(e));
    chk("stall_cycles_a", 32'(bus_a.stall_cycles), 32'(cnt_a));
    chk("stall_cycles_b", 32'(bus_b.stall_cycles), 32'(cnt_b));
    @(posedge clk);
    #1;
    rem = rn;
    if (!e[9]) begin
      if (cnt_a < 65535) cnt_a++;
      if (cnt_b < 15) cnt_b++;
    end
  endtask

  initial begin
    // Reset state while reset is held.
    #2;
    chk("reset_ctl_a", 32'(vec_a()), 32'd0);
    chk("reset_cnt_a", 32'(bus_a.stall_cycles), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("lit_idle", 32'(last_vec), 32'(10'b11111_000_00));

    // Load-use stall for one cycle.
    cycle(1, 0, 0, 0);
    chk("lit_stall_vec", 32'(last_vec), 32'(10'b00111_010_00));
    chk("lit_cnt_stall", 32'(bus_a.stall_cycles), 32'd1);

    // Branch squashes a simultaneous stall request.
    cycle(1, 1, 0, 0);
    chk("lit_branch_vec", 32'(last_vec), 32'(10'b11111_110_00));
    chk("lit_cnt_branch", 32'(bus_a.stall_cycles), 32'd1);

    // Single mul/div: 3 frozen cycles then done.
    repeat (4) cycle(0, 0, 1, 0);
    chk("lit_md_done", 32'(last_vec), 32'(10'b11111_000_11));
    chk("lit_cnt_md", 32'(bus_a.stall_cycles), 32'd4);

    // Mul/div with two memory-wait cycles at the last countdown step.
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    chk("lit_mem_vec", 32'(last_vec), 32'(10'b00000_000_10));
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    chk("lit_md_mem_done", 32'(last_vec), 32'(10'b11111_000_11));
    chk("lit_cnt_md_mem", 32'(bus_a.stall_cycles), 32'd9);

    // Back-to-back mul/div ops.
    repeat (8) cycle(0, 0, 1, 0);
    chk("lit_cnt_b2b", 32'(bus_a.stall_cycles), 32'd15);

    // Stall request arriving in the done cycle keeps the front end moving.
    repeat (3) cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    chk("lit_done_stall", 32'(last_vec), 32'(10'b11111_010_11));

    // Branch with muldiv_ex never enters the busy state.
    cycle(0, 1, 1, 0);
    cycle(0, 0, 0, 0);
    chk("lit_branch_md", 32'(last_vec), 32'(10'b11111_000_00));

    // Reset asserted mid-cycle while busy with two countdown steps left.
    cycle(0, 0, 1, 0);
    stall_id_req    = 1'b0;
    branch_taken_ex = 1'b0;
    muldiv_ex       = 1'b1;
    mem_busy        = 1'b0;
    #2;
    chk("lit_pre_reset_busy", 32'(bus_a.muldiv_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_mid_ctl_a", 32'(vec_a()), 32'd0);
    chk("reset_mid_ctl_b", 32'(vec_b()), 32'd0);
    chk("reset_mid_cnt_a", 32'(bus_a.stall_cycles), 32'd0);
    rem   = 0;
    cnt_a = 0;
    cnt_b = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(0, 0, 0, 0);
    chk("lit_post_reset", 32'(last_vec), 32'(10'b11111_000_00));

    // Long stall: 4-bit counter saturates at 15.
    repeat (20) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("lit_sat_b", 32'(bus_b.stall_cycles), 32'd15);
    chk("lit_cnt_a20", 32'(bus_a.stall_cycles), 32'd20);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    chk("lit_sat_hold_b", 32'(bus_b.stall_cycles), 32'd15);
    chk("lit_cnt_a22", 32'(bus_a.stall_cycles), 32'd22);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage datapath.
- Turns load-use stall requests from the ID-stage hazard detector, EX branch redirects, multi-cycle mul/div occupancy and data-memory wait into per-stage register enables, flush and bubble controls.
- Owns the mul/div occupancy FSM and latency counter.
- Keeps a saturating count of frontend stall cycles for performance debug.

Parameters:
MULDIV_LAT, 4, total EX occupancy in cycles of a mul/div op; legal range 2..15
CNT_W, 16, width of stall_cycles counter

Ports:
clk  in  1  single system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
stall_id_req  in  1  load-use stall request from the ID-stage hazard detector
branch_taken_ex  in  1  branch/jump in EX resolved taken; PC loads the target this cycle
muldiv_ex  in  1  instruction currently in EX is mul/div
mem_busy  in  1  data memory not ready; MEM stage must hold
en_pc  out  1  PC register load enable
en_if_id  out  1  IF/ID register enable
en_id_ex  out  1  ID/EX register enable
en_ex_mem  out  1  EX/MEM register enable
en_mem_wb  out  1  MEM/WB register enable
flush_if_id  out  1  load NOP into IF/ID (qualified by en_if_id)
bubble_id_ex  out  1  load NOP into ID/EX (qualified by en_id_ex)
bubble_ex_mem  out  1  load NOP into EX/MEM (qualified by en_ex_mem)
muldiv_busy  out  1  FSM in MD_BUSY
muldiv_done  out  1  last EX cycle of a mul/div op
stall_cycles  out  CNT_W  saturating count of cycles with en_pc=0 and reset low

Behaviour:
- State: FSM {RUN, MD_BUSY}; down-counter md_cnt, 4 bits; stall_cycles register.
- Reset while asserted, independent of clk: state=RUN, md_cnt=0, stall_cycles=0.
- Outputs while reset is asserted: all en_*=0, flush_if_id=0, all bubbles=0, muldiv_busy=0, muldiv_done=0.
- Outputs are combinational from state, md_cnt and inputs.
- Evaluation order: the first matching rule applies. Any output not named by the rule is en_*=1, others 0.

Output rules:
- R1 mem_busy=1 (any state): all en_*=0, no flush or bubble. md_cnt and state hold. muldiv_done=0.
- R2 state=MD_BUSY, md_cnt!=0: en_pc=en_if_id=en_id_ex=0. en_ex_mem=1 with bubble_ex_mem=1. en_mem_wb=1. branch_taken_ex and stall_id_req are ignored.
- R3 state=MD_BUSY, md_cnt==0: muldiv_done=1, all en_*=1. Then apply R4/R5 for flush/bubble as if in RUN.
- R4 branch_taken_ex=1: all en_*=1, flush_if_id=1, bubble_id_ex=1. A simultaneous stall_id_req is dropped; the requester is squashed.
- R5 stall_id_req=1: en_pc=en_if_id=0, bubble_id_ex=1.
- R6 default: all en_*=1, no flush or bubble.

Transitions (only when mem_busy=0):
- RUN, muldiv_ex=1, branch_taken_ex=0: go to MD_BUSY, md_cnt<=MULDIV_LAT-2. That cycle outputs follow R2. Net EX occupancy = MULDIV_LAT cycles including the done cycle.
- RUN, muldiv_ex=1, branch_taken_ex=1: impossible by construction (single EX instruction). Branch wins; no entry to MD_BUSY.
- MD_BUSY, md_cnt!=0: md_cnt<=md_cnt-1.
- MD_BUSY, md_cnt==0: go to RUN. The mul/div instruction is in EX/MEM next cycle, so muldiv_ex is the following instruction. A back-to-back mul/div re-enters MD_BUSY from RUN the next cycle.
- Reset mid-operation: FSM returns to RUN immediately; the partial mul/div op is abandoned.

Counters and flags:
- stall_cycles: increments when en_pc=0, saturates at all-ones (no wrap), and holds when en_pc=1.
- muldiv_busy = (state==MD_BUSY).

Test Plan:
- Reset asserted mid-cycle with state=MD_BUSY, md_cnt=2 -> outputs immediately all 0; after release, en_*=1, muldiv_busy=0, stall_cycles=0.
- stall_id_req=1 for 1 cycle -> en_pc=0, en_if_id=0, bubble_id_ex=1, en_id_ex/en_ex_mem/en_mem_wb=1; stall_cycles 0->1.
- branch_taken_ex=1 with stall_id_req=1 -> flush_if_id=1, bubble_id_ex=1, all en_*=1; stall_cycles unchanged.
- muldiv_ex=1 in RUN, MULDIV_LAT=4 -> 3 cycles en_pc=0 with bubble_ex_mem=1, 4th cycle muldiv_done=1 and all en_*=1; stall_cycles +3.
- Same mul/div with mem_busy=1 for 2 cycles at md_cnt=1 -> all en_*=0 those cycles, md_cnt holds at 1; muldiv_done arrives 2 cycles late; stall_cycles +5 total.
- CNT_W=4, hold stall_id_req=1 for 20 cycles -> stall_cycles reaches 15 and stays 15.
